// File: rtl/multu_hilo.sv
// Iterative unsigned 32x32->64 multiplier with MIPS-style Hi/Lo registers and MFHI/MFLO readout.
// Define MULTU_HILO_RADIX4_EN to retire two multiplier bits per cycle (16 RUN cycles instead of 32).
module multu_hilo #(
  parameter logic [5:0] MULTU = 6'b011001,
  parameter logic [5:0] MFHI  = 6'b010000,
  parameter logic [5:0] MFLO  = 6'b010010
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] dataA,
  input  logic [31:0] dataB,
  input  logic [5:0]  Signal,
  input  logic        start,
  output logic [31:0] HiOut,
  output logic [31:0] LoOut,
  output logic [31:0] dataOut,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

`ifdef MULTU_HILO_RADIX4_EN
  localparam logic [4:0] LAST_CNT = 5'd15;
`else
  localparam logic [4:0] LAST_CNT = 5'd31;
`endif

  state_t      state_q, state_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [63:0] acc_q, acc_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        issue;
  logic        last_iter;
  logic [63:0] acc_step;
  logic [31:0] b_step;

  assign issue     = start && (Signal == MULTU) && (state_q != RUN);
  assign last_iter = (cnt_q == LAST_CNT);

  // Shift-add step: add the selected multiple of A into the upper half, then
  // shift the whole accumulator right so retired product bits fill from the top.
`ifdef MULTU_HILO_RADIX4_EN
  logic [33:0] pp;
  logic [34:0] psum;
  always_comb begin
    case (b_q[1:0])
      2'd0:    pp = 34'd0;
      2'd1:    pp = {2'b00, a_q};
      2'd2:    pp = {1'b0, a_q, 1'b0};
      default: pp = {2'b00, a_q} + {1'b0, a_q, 1'b0};
    endcase
    psum     = {3'b000, acc_q[63:32]} + {1'b0, pp};
    acc_step = {psum[33:0], acc_q[31:2]};
    b_step   = {2'b00, b_q[31:2]};
  end
`else
  logic [32:0] psum;
  always_comb begin
    psum     = {1'b0, acc_q[63:32]} + {1'b0, (b_q[0] ? a_q : 32'h0)};
    acc_step = {psum, acc_q[31:1]};
    b_step   = {1'b0, b_q[31:1]};
  end
`endif

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= 32'h0;
      b_q     <= 32'h0;
      acc_q   <= 64'h0;
      cnt_q   <= 5'd0;
      hi_q    <= 32'h0;
      lo_q    <= 32'h0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (issue) state_d = RUN;
      RUN:     if (last_iter) state_d = DONE;
      DONE:    state_d = issue ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    hi_d  = hi_q;
    lo_d  = lo_q;
    if (issue) begin
      a_d   = dataA;
      b_d   = dataB;
      acc_d = 64'h0;
      cnt_d = 5'd0;
    end else if (state_q == RUN) begin
      b_d   = b_step;
      acc_d = acc_step;
      cnt_d = cnt_q + 5'd1;
      if (last_iter) begin
        hi_d = acc_step[63:32];
        lo_d = acc_step[31:0];
      end
    end
  end

  // Outputs
  always_comb begin
    busy    = (state_q == RUN);
    done    = (state_q == DONE);
    HiOut   = hi_q;
    LoOut   = lo_q;
    dataOut = 32'h0;
    if (Signal == MFHI)      dataOut = hi_q;
    else if (Signal == MFLO) dataOut = lo_q;
  end

endmodule

// File: tb/tb_multu_hilo.sv
// Bench for multu_hilo: vector table, random products against 64-bit arithmetic, and
// hand sequences for ignored issue, reset abort and back-to-back issue in DONE.
module tb_multu_hilo;

  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
`ifdef MULTU_HILO_RADIX4_EN
  localparam int NRUN = 16;
`else
  localparam int NRUN = 32;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] dataA, dataB;
  logic [5:0]  Signal;
  logic        start;
  logic [31:0] HiOut, LoOut, dataOut;
  logic        busy, done;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_hi, exp_lo;

  multu_hilo dut (
    .clk(clk), .reset(reset), .dataA(dataA), .dataB(dataB), .Signal(Signal),
    .start(start), .HiOut(HiOut), .LoOut(LoOut), .dataOut(dataOut),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t tbl[8];

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] wa, wb;
    wa = {32'h0, a};
    wb = {32'h0, b};
    return wa * wb;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    dataA  = a;
    dataB  = b;
    Signal = F_MULTU;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    dataA  = $urandom;
    dataB  = $urandom;
  endtask

  // Counts busy cycles starting from the current sampled cycle; bounded.
  task automatic wait_done(output int n);
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      tick();
    end
  endtask

  task automatic check_reads(input string tag);
    Signal = F_MFHI; #1; chk({tag, "_mfhi"}, {32'h0, dataOut}, {32'h0, exp_hi});
    Signal = F_MFLO; #1; chk({tag, "_mflo"}, {32'h0, dataOut}, {32'h0, exp_lo});
    Signal = 6'h3F;  #1; chk({tag, "_other"}, {32'h0, dataOut}, 64'h0);
  endtask

  task automatic do_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] prod);
    int n;
    issue(a, b);
    chk({tag, "_hold_hi"}, {32'h0, HiOut}, {32'h0, exp_hi});
    chk({tag, "_hold_lo"}, {32'h0, LoOut}, {32'h0, exp_lo});
    wait_done(n);
    chk({tag, "_busy_cycles"}, 64'(n), 64'(NRUN));
    chk({tag, "_done"}, {63'h0, done}, 64'h1);
    exp_hi = prod[63:32];
    exp_lo = prod[31:0];
    chk({tag, "_hilo"}, {HiOut, LoOut}, prod);
    check_reads(tag);
    tick();
    chk({tag, "_done_clr"}, {63'h0, done}, 64'h0);
  endtask

  initial begin
    int n;
    int dcnt;
    logic [31:0] ra, rb;

    tbl[0] = '{32'h00000003, 32'h00000005, 32'h00000000, 32'h0000000F};
    tbl[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    tbl[2] = '{32'h00000000, 32'hDEADBEEF, 32'h00000000, 32'h00000000};
    tbl[3] = '{32'h80000000, 32'h00000002, 32'h00000001, 32'h00000000};
    tbl[4] = '{32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF};
    tbl[5] = '{32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    tbl[6] = '{32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE};
    tbl[7] = '{32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};

    reset = 1'b1; start = 1'b0; dataA = '0; dataB = '0; Signal = 6'h0;
    tick(); tick();
    reset = 1'b0;
    exp_hi = 32'h0; exp_lo = 32'h0;
    chk("rst_busy", {63'h0, busy}, 64'h0);
    chk("rst_done", {63'h0, done}, 64'h0);
    chk("rst_hilo", {HiOut, LoOut}, 64'h0);
    check_reads("rst");

    // Non-MULTU funct with start must not issue
    dataA = 32'h5; dataB = 32'h6; Signal = F_MFHI; start = 1'b1;
    tick();
    start = 1'b0;
    chk("bad_funct_busy", {63'h0, busy}, 64'h0);

    for (int i = 0; i < 8; i++)
      do_mul($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b, {tbl[i].hi, tbl[i].lo});

    for (int i = 0; i < 20; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 5 == 0) rb = 32'hFFFFFFFF;
      do_mul($sformatf("rnd%0d", i), ra, rb, ref_mul(ra, rb));
    end

    // Issue while RUN is ignored
    issue(32'd7, 32'd9);
    repeat (9) tick();
    dataA = 32'd2; dataB = 32'd2; Signal = F_MULTU; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(n);
    chk("ign_busy_rest", 64'(n), 64'(NRUN - 10));
    chk("ign_done", {63'h0, done}, 64'h1);
    exp_hi = 32'h0; exp_lo = 32'h3F;
    chk("ign_hilo", {HiOut, LoOut}, 64'h3F);
    tick();

    // Reset mid-RUN aborts
    issue(32'h12345678, 32'h12345678);
    repeat (NRUN / 2 - 1) tick();
    chk("abort_busy_before", {63'h0, busy}, 64'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_busy", {63'h0, busy}, 64'h0);
    chk("abort_hilo", {HiOut, LoOut}, 64'h0);
    exp_hi = 32'h0; exp_lo = 32'h0;
    dcnt = 0;
    for (int i = 0; i < NRUN + 8; i++) begin
      if (done === 1'b1) dcnt++;
      tick();
    end
    chk("abort_no_done", 64'(dcnt), 64'h0);
    chk("abort_hilo_after", {HiOut, LoOut}, 64'h0);

    // Back-to-back: second issue accepted in the DONE cycle
    issue(32'd3, 32'd5);
    wait_done(n);
    chk("b2b_first_done", {63'h0, done}, 64'h1);
    chk("b2b_first_hilo", {HiOut, LoOut}, 64'hF);
    exp_hi = 32'h0; exp_lo = 32'hF;
    issue(32'h00010000, 32'h00010000);
    chk("b2b_busy", {63'h0, busy}, 64'h1);
    chk("b2b_done_low", {63'h0, done}, 64'h0);
    chk("b2b_old_visible", {HiOut, LoOut}, 64'hF);
    wait_done(n);
    chk("b2b_busy_cycles", 64'(n), 64'(NRUN));
    chk("b2b_second_done", {63'h0, done}, 64'h1);
    chk("b2b_second_hilo", {HiOut, LoOut}, 64'h0000000100000000);
    exp_hi = 32'h1; exp_lo = 32'h0;
    check_reads("b2b");
    tick();
    chk("b2b_idle", {62'h0, busy, done}, 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multu_hilo.md
MULTU_HILO -- requirements
Module: multu_hilo

Interface
REQ-001 The block SHALL have parameter MULTU, default 6'b011001, meaning the funct code that selects the unsigned multiply.
REQ-002 The block SHALL have parameter MFHI, default 6'b010000, meaning the funct code that reads Hi.
REQ-003 The block SHALL have parameter MFLO, default 6'b010010, meaning the funct code that reads Lo.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port dataA, input, 32 bits: multiplicand.
REQ-007 The block SHALL have port dataB, input, 32 bits: multiplier.
REQ-008 The block SHALL have port Signal, input, 6 bits: instruction funct code.
REQ-009 The block SHALL have port start, input, 1 bit: one-cycle issue strobe, qualified by Signal==MULTU.
REQ-010 The block SHALL have port HiOut, output, 32 bits: Hi register, holding the upper product word.
REQ-011 The block SHALL have port LoOut, output, 32 bits: Lo register, holding the lower product word.
REQ-012 The block SHALL have port dataOut, output, 32 bits: MFHI/MFLO read result.
REQ-013 The block SHALL have port busy, output, 1 bit: high while a multiply iterates.
REQ-014 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.

Function
REQ-015 The FSM SHALL have states IDLE, RUN and DONE, and SHALL leave reset in IDLE.
REQ-016 An issue SHALL be accepted when start=1 and Signal==MULTU in state IDLE or DONE.
  - On acceptance, the block SHALL latch dataA and dataB, clear the 64-bit accumulator and iteration counter, and enter RUN.
REQ-017 An issue attempted in state RUN SHALL be ignored, with no effect on operands, counter or result.
REQ-018 Each RUN cycle SHALL retire one multiplier bit, LSB first, using shift-add.
  - The partial sum SHALL be 33 bits wide so the carry is kept.
  - The product SHALL be exact unsigned 32x32->64, with no overflow flag.
REQ-019 The FSM SHALL spend exactly 32 RUN cycles, then move RUN->DONE.
  - Hi/Lo SHALL be written on the same edge as RUN->DONE: Hi=product[63:32], Lo=product[31:0].
REQ-020 The state DONE SHALL last one cycle, with done=1, and SHALL then go to IDLE unless a new issue is accepted.
REQ-021 busy SHALL equal (state==RUN); done SHALL equal (state==DONE).
REQ-022 The latency SHALL be as follows:
  - Issue sampled at edge E0.
  - Hi/Lo SHALL be valid after edge E32.
  - done SHALL be high in the cycle following E32.
REQ-023 Hi/Lo SHALL hold their values until the next multiply completes.
  - Reads during RUN SHALL return the previous result; software handles the hazard.
REQ-024 dataOut SHALL be combinational from Signal:
  - HiOut if Signal==MFHI.
  - LoOut if Signal==MFLO.
  - 32'h0 otherwise.
REQ-025 A new issue accepted in DONE SHALL start the next multiply at once; the old Hi/Lo stay visible until that multiply completes.
REQ-026 The operands dataA and dataB MAY change after E0 without affecting the result.

Reset
REQ-027 When reset=1 at a clock edge, the block SHALL force the following, overriding start:
  - state=IDLE.
  - Hi=Lo=0.
  - Accumulator, counter and latched operands = 0.
  - busy=0, done=0.
REQ-028 A reset asserted during RUN SHALL abort the operation; no done pulse and no Hi/Lo write SHALL follow.

Configuration
REQ-029 The block SHALL have macro MULTU_HILO_RADIX4_EN with the following behaviour:
  - When defined, RUN SHALL retire 2 multiplier bits per cycle (add 0, A, 2A or 3A), which needs a 35-bit partial sum.
  - When defined, RUN SHALL last 16 cycles, with Hi/Lo valid after edge E16.
  - When undefined, the block SHALL use radix-2 with 32 RUN cycles, as REQ-019 states.
  - Product values SHALL be identical in both builds.

Verification
REQ-030 Reset, then Signal=MFHI and then MFLO -> dataOut=0x00000000 both times, with busy=0 and done=0.
REQ-031 Issue A=3, B=5 -> busy high for 32 cycles (16 with the macro) and done pulses once; then Hi=0x00000000, Lo=0x0000000F, and MFLO gives dataOut=0x0000000F.
REQ-032 Issue A=B=0xFFFFFFFF -> Hi=0xFFFFFFFE, Lo=0x00000001.
REQ-033 Issue A=7, B=9; at RUN cycle 10 issue A=B=2 -> the second issue is ignored and the final Lo=0x0000003F.
REQ-034 Issue A=B=0x12345678; reset at RUN cycle 16 -> busy=0 on the next cycle, Hi=Lo=0, and done never pulses.
REQ-035 Back-to-back: issue A=3, B=5, then issue A=B=0x00010000 in the DONE cycle -> the first done gives Lo=0x0000000F and the second gives Hi=0x00000001, Lo=0x00000000.
